// File: rtl/pipe_pkg.sv
// Shared Y86 pipeline definitions: stat codes, NOP fields
// and the bubble payload builder used by stage instances.
package pipe_pkg;

    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] AOK  = 3'd1;
    localparam logic [2:0] HLT  = 3'd2;
    localparam logic [2:0] ADR  = 3'd3;
    localparam logic [2:0] INS  = 3'd4;

    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] RNONE = 4'hF;

    localparam int MAX_PAYLOAD_W = 256;

    // Layout from the MSB down: icode, ifun, dstE, dstM, rest zero.
    function automatic logic [MAX_PAYLOAD_W-1:0] bubble_payload(
        input int w
    );
        logic [MAX_PAYLOAD_W-1:0] p;
        p = '0;
        p[w-1  -: 4] = INOP;
        p[w-9  -: 4] = RNONE;
        p[w-13 -: 4] = RNONE;
        return p;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Step only while below the ceiling.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic Y86 pipeline register with stall, bubble,
// optional exception freeze and stall/bubble counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                   PAYLOAD_W      = 128,
    parameter logic [PAYLOAD_W-1:0] BUBBLE_PAYLOAD = {PAYLOAD_W{1'b0}},
    parameter int                   STAT_W         = 3,
    parameter bit                   FREEZE_ON_EXC  = 1'b0,
    parameter int                   CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [STAT_W-1:0]    in_stat,
    input  logic                 in_valid,
    input  logic                 stall,
    input  logic                 bubble,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [STAT_W-1:0]    out_stat,
    output logic                 out_valid,
    output logic                 frozen,
    output logic                 ctl_conflict,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [STAT_W-1:0]    stat_q, stat_d;
    logic                 valid_q, valid_d;
    logic                 frozen_q, frozen_d;
    logic                 conflict_q, conflict_d;

    logic do_bub;
    logic do_stall;
    logic do_load;
    logic exc_in;

    // Resolve the action for this edge: freeze > bubble > stall > load.
    always_comb begin
        do_bub   = !frozen_q && bubble;
        do_stall = !frozen_q && !bubble && stall;
        do_load  = !frozen_q && !bubble && !stall;
        exc_in   = (in_stat != STAT_W'(SBUB))
                && (in_stat != STAT_W'(AOK));

        payload_d = payload_q;
        stat_d    = stat_q;
        valid_d   = valid_q;
        if (do_bub) begin
            payload_d = BUBBLE_PAYLOAD;
            stat_d    = STAT_W'(SBUB);
            valid_d   = 1'b0;
        end else if (do_load) begin
            payload_d = in_payload;
            stat_d    = in_stat;
            valid_d   = in_valid;
        end

        frozen_d   = frozen_q | (FREEZE_ON_EXC && do_load && exc_in);
        conflict_d = conflict_q | (!frozen_q && stall && bubble);
    end

    // Stage contents and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            payload_q  <= BUBBLE_PAYLOAD;
            stat_q     <= STAT_W'(SBUB);
            valid_q    <= 1'b0;
            frozen_q   <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            payload_q  <= payload_d;
            stat_q     <= stat_d;
            valid_q    <= valid_d;
            frozen_q   <= frozen_d;
            conflict_q <= conflict_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_bub),
        .count (bubble_cnt)
    );

    assign out_payload  = payload_q;
    assign out_stat     = stat_q;
    assign out_valid    = valid_q;
    assign frozen       = frozen_q;
    assign ctl_conflict = conflict_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: two stage registers, freeze on (A) and off (B),
// sharing one stimulus stream.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int PW = 32;
    localparam int CW = 4;
    localparam logic [MAX_PAYLOAD_W-1:0] BP_FULL = bubble_payload(PW);
    localparam logic [PW-1:0] BP_DUT = BP_FULL[PW-1:0];
    // icode=1, ifun=0, dstE=F, dstM=F
    localparam logic [31:0] BP = 32'h10FF_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] in_payload;
    logic [2:0]    in_stat;
    logic          in_valid;
    logic          stall;
    logic          bubble;

    logic [PW-1:0] a_pay, b_pay;
    logic [2:0]    a_stat, b_stat;
    logic          a_val, b_val;
    logic          a_frz, b_frz;
    logic          a_cfl, b_cfl;
    logic [CW-1:0] a_scnt, b_scnt;
    logic [CW-1:0] a_bcnt, b_bcnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .PAYLOAD_W(PW), .BUBBLE_PAYLOAD(BP_DUT), .STAT_W(3),
        .FREEZE_ON_EXC(1'b1), .CNT_W(CW)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .in_payload(in_payload),
        .in_stat(in_stat), .in_valid(in_valid), .stall(stall),
        .bubble(bubble), .out_payload(a_pay), .out_stat(a_stat),
        .out_valid(a_val), .frozen(a_frz), .ctl_conflict(a_cfl),
        .stall_cnt(a_scnt), .bubble_cnt(a_bcnt)
    );

    pipe_stage_reg #(
        .PAYLOAD_W(PW), .BUBBLE_PAYLOAD(BP_DUT), .STAT_W(3),
        .FREEZE_ON_EXC(1'b0), .CNT_W(CW)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .in_payload(in_payload),
        .in_stat(in_stat), .in_valid(in_valid), .stall(stall),
        .bubble(bubble), .out_payload(b_pay), .out_stat(b_stat),
        .out_valid(b_val), .frozen(b_frz), .ctl_conflict(b_cfl),
        .stall_cnt(b_scnt), .bubble_cnt(b_bcnt)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic [2:0] s,
                         input logic v, input logic st, input logic bu);
        in_payload = p;
        in_stat    = s;
        in_valid   = v;
        stall      = st;
        bubble     = bu;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(32'h0, SBUB, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();

        check("bp_func", 32'(BP_DUT), BP);
        check("rst_pay", 32'(a_pay), BP);
        check("rst_stat", 32'(a_stat), 32'(SBUB));
        check("rst_val", 32'(a_val), 32'd0);
        check("rst_frz", 32'(a_frz), 32'd0);
        check("rst_cfl", 32'(a_cfl), 32'd0);
        check("rst_scnt", 32'(a_scnt), 32'd0);
        check("rst_bcnt", 32'(a_bcnt), 32'd0);
        rst_n = 1'b1;

        // async reset mid-cycle
        drive(32'hABCD, AOK, 1'b1, 1'b0, 1'b0);
        tick();
        check("ld_abcd", 32'(a_pay), 32'hABCD);
        #3 rst_n = 1'b0;
        #1;
        check("arst_pay", 32'(a_pay), BP);
        check("arst_stat", 32'(a_stat), 32'(SBUB));
        check("arst_val", 32'(a_val), 32'd0);
        check("arst_pay_b", 32'(b_pay), BP);
        rst_n = 1'b1;

        // first edge after reset release loads
        drive(32'h1234, AOK, 1'b1, 1'b0, 1'b0);
        tick();
        check("ld_pay", 32'(a_pay), 32'h1234);
        check("ld_stat", 32'(a_stat), 32'(AOK));
        check("ld_val", 32'(a_val), 32'd1);

        drive(32'h5555, AOK, 1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        check("stl_pay", 32'(a_pay), 32'h1234);
        check("stl_cnt_a", 32'(a_scnt), 32'd3);
        check("stl_cnt_b", 32'(b_scnt), 32'd3);

        drive(32'h5555, AOK, 1'b1, 1'b0, 1'b1);
        tick();
        check("bub_pay", 32'(a_pay), BP);
        check("bub_stat", 32'(a_stat), 32'(SBUB));
        check("bub_val", 32'(a_val), 32'd0);
        check("bub_cnt", 32'(a_bcnt), 32'd1);
        check("bub_cfl", 32'(a_cfl), 32'd0);

        // stall + bubble together
        drive(32'h1234, AOK, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h1234, AOK, 1'b1, 1'b1, 1'b1);
        tick();
        check("cfl_pay", 32'(a_pay), BP);
        check("cfl_set", 32'(a_cfl), 32'd1);
        check("cfl_bcnt", 32'(a_bcnt), 32'd2);
        check("cfl_scnt", 32'(a_scnt), 32'd3);
        drive(32'h4242, AOK, 1'b1, 1'b0, 1'b0);
        tick();
        check("cfl_stick", 32'(a_cfl), 32'd1);
        check("cfl_ld", 32'(a_pay), 32'h4242);

        // invalid load still captures payload
        drive(32'h0099, AOK, 1'b0, 1'b0, 1'b0);
        tick();
        check("inv_pay", 32'(a_pay), 32'h0099);
        check("inv_val", 32'(a_val), 32'd0);

        // saturation from 3
        drive(32'h0, AOK, 1'b1, 1'b1, 1'b0);
        repeat (11) tick();
        check("sat_14", 32'(a_scnt), 32'd14);
        repeat (9) tick();
        check("sat_15", 32'(a_scnt), 32'd15);
        check("sat_pay", 32'(a_pay), 32'h0099);

        // exception freeze
        drive(32'h0077, ADR, 1'b1, 1'b0, 1'b0);
        tick();
        check("frz_set_a", 32'(a_frz), 32'd1);
        check("frz_off_b", 32'(b_frz), 32'd0);
        drive(32'h0088, AOK, 1'b1, 1'b0, 1'b0);
        tick();
        check("frz_pay_a", 32'(a_pay), 32'h0077);
        check("frz_stat_a", 32'(a_stat), 32'(ADR));
        check("nofrz_pay_b", 32'(b_pay), 32'h0088);
        check("nofrz_stat_b", 32'(b_stat), 32'(AOK));
        drive(32'h0088, AOK, 1'b1, 1'b0, 1'b1);
        tick();
        check("frz_bub_pay", 32'(a_pay), 32'h0077);
        check("frz_bub_cnt", 32'(a_bcnt), 32'd2);
        check("b_bub_cnt", 32'(b_bcnt), 32'd3);
        check("b_bub_pay", 32'(b_pay), BP);

        rst_n = 1'b0;
        #1;
        check("rst_frz2", 32'(a_frz), 32'd0);
        check("rst_cfl2", 32'(a_cfl), 32'd0);
        rst_n = 1'b1;

        // bubble on the exception edge blocks the freeze
        drive(32'h0077, ADR, 1'b1, 1'b0, 1'b1);
        tick();
        check("bub_nofrz", 32'(a_frz), 32'd0);
        check("bub_nofrz_pay", 32'(a_pay), BP);
        drive(32'h0055, HLT, 1'b1, 1'b0, 1'b0);
        tick();
        check("hlt_frz", 32'(a_frz), 32'd1);
        check("hlt_pay", 32'(a_pay), 32'h0055);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised Y86 pipeline-stage register. One instance replaces each per-stage register (F/D/E/M/W).
- Carries a flat payload plus a stat field and a valid bit. Supports load, stall (hold), bubble (NOP injection) and an optional exception freeze.
- Keeps saturating performance counters for stalls and bubbles.
- Sits between any two pipe stages. Stall and bubble come from the hazard control unit.

Parameters:
- PAYLOAD_W, 128: width of the stage payload (icode, ifun, valA, valE, dstE, dstM, … packed by the instantiator).
- BUBBLE_PAYLOAD, {PAYLOAD_W{1'b0}}: payload value on reset/bubble. Instantiator encodes icode=INOP (4'h1) and dst=RNONE (4'hF).
- STAT_W, 3: stat field width.
- FREEZE_ON_EXC, 0: 1 means loads are blocked once a non-AOK, non-bubble stat is held.
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_payload  in  PAYLOAD_W  upstream stage payload
- in_stat  in  STAT_W  upstream status
- in_valid  in  1  upstream holds a real instruction
- stall  in  1  hold current contents
- bubble  in  1  replace contents with NOP
- out_payload  out  PAYLOAD_W  registered payload
- out_stat  out  STAT_W  registered status
- out_valid  out  1  registered valid
- frozen  out  1  exception freeze active
- ctl_conflict  out  1  sticky: stall and bubble were seen together
- stall_cnt  out  CNT_W  saturating count of stalled cycles
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Stat encoding (shared package): SBUB=0, AOK=1, HLT=2, ADR=3, INS=4.
- Reset (rst_n low, asynchronous): all outputs take their reset values immediately, independent of clk.
  - out_payload=BUBBLE_PAYLOAD, out_stat=SBUB, out_valid=0
  - frozen=0, ctl_conflict=0, stall_cnt=0, bubble_cnt=0
- Action at each rising clk edge, evaluated in priority order:
  1. frozen=1: hold all data outputs. Counters do not change.
  2. bubble=1: out_payload=BUBBLE_PAYLOAD, out_stat=SBUB, out_valid=0. bubble_cnt+1.
  3. stall=1: hold all data outputs. stall_cnt+1.
  4. Otherwise (load): out_payload=in_payload, out_stat=in_stat, out_valid=in_valid.
- Bubble wins over stall. If stall and bubble are both 1 on an edge (not frozen), ctl_conflict is set to 1 and stays set until reset.
- Latency: 1 cycle from input to output on a load. No combinational path from inputs to outputs.
- Freeze: when FREEZE_ON_EXC=1, frozen is set on the edge after a load that captures in_stat not in {SBUB, AOK}.
  - frozen stays set until reset.
  - A bubble on that same edge prevents freezing.
  - With FREEZE_ON_EXC=0, frozen is tied to 0.
- Counters saturate at 2^CNT_W−1; they never wrap.
- Deasserting reset mid-operation: the first edge after rst_n rises performs a normal action per the priority list.
- in_valid=0 with a load: the payload is still captured and out_valid=0. The consumer ignores the payload.

Decomposition:
- Package pipe_pkg holds:
  - stat constants SBUB/AOK/HLT/ADR/INS
  - INOP=4'h1, RNONE=4'hF
  - a function bubble_payload(PAYLOAD_W) used by the per-stage instantiations
- Sub-module sat_counter (parameter W; ports clk, rst_n, inc, count) is instantiated twice for stall_cnt and bubble_cnt.

Test Plan:
- Reset: rst_n=0 mid-cycle with out_payload=0xABCD → outputs go to BUBBLE_PAYLOAD / SBUB / valid 0 before the next edge; counters are 0.
- Load then stall: in_payload=0x1234, in_stat=AOK, load → next cycle out=0x1234. Apply stall 3 cycles with in_payload=0x5555 → out stays 0x1234, stall_cnt=3.
- Bubble: out holding 0x1234, bubble=1 one cycle → out_payload=BUBBLE_PAYLOAD, out_stat=0, out_valid=0, bubble_cnt=1.
- Conflict: stall=1 and bubble=1 together → bubble applied, ctl_conflict=1. It stays 1 after both drop and clears only on reset.
- Freeze (FREEZE_ON_EXC=1): load in_stat=ADR with payload 0x77, then load AOK/0x88 → out stays 0x77/ADR and frozen=1.
  - Repeat with FREEZE_ON_EXC=0 → out=0x88.
- Saturation (CNT_W=4): stall for 20 cycles → stall_cnt reaches 15 and holds there.
